aes_key_schedule: RTL and testbench

Parametrised AES key-expansion engine supporting AES-128/192/256, selected per key at run time. It accepts a cipher key over a valid/ready handshake and generates the FIPS-197 word schedule one 32-bit word per cycle. It delivers 128-bit round keys in order over a back-pressured valid/ready output. It sits between the key-load interface and the round datapath, replacing the fixed 128-bit single-round key expansion.

---
 rtl/aes_key_schedule.sv | 251 +++++++++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: run-time selectable AES-128/192/256 key expansion.
// Generates one schedule word per cycle and delivers 128-bit round keys
// over a back-pressured valid/ready port.
// Optional build macro AES_KEYEXP_INV_EN adds a round-key buffer and a DRAIN
// state so a key can be delivered in reverse (decryption) order.
module aes_key_schedule #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  input  logic [1:0]              key_len,
  input  logic                    key_dir,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [127:0]            rk_data,
  output logic [3:0]              rk_round,
  output logic                    rk_last,
  output logic                    busy,
  output logic                    key_err
);
  localparam int NW = MAX_KEY_BITS / 32;  // window depth = largest Nk
  localparam int NB = NW + 7;             // round keys of the largest schedule

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1
`ifdef AES_KEYEXP_INV_EN
    , S_DRAIN = 2'd2
`endif
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t                  state_q, state_d;
  logic [3:0]              nk_q, nk_d, nr_q, nr_d;
  logic [5:0]              i_q, i_d;
  logic [2:0]              j_q, j_d;      // i mod Nk, kept as a counter
  logic [7:0]              rcon_q, rcon_d;
  logic [MAX_KEY_BITS-1:0] key_q, key_d;  // cipher key, shifted out one word per write
  logic [31:0]             win_q [NW];    // win_q[0] is w[i-1]
  logic [31:0]             win_d [NW];
  logic [95:0]             asm_q, asm_d;  // first three words of the round in progress
  logic                    rk_valid_q, rk_valid_d;
  logic [127:0]            rk_data_q, rk_data_d;
  logic [3:0]              rk_round_q, rk_round_d;
  logic                    rk_last_q, rk_last_d;
  logic                    key_err_q, key_err_d;
  logic [31:0]             old_w, temp, new_w;
  logic                    len_bad, round_done, stall, rev;

`ifdef AES_KEYEXP_INV_EN
  logic                    dir_q, dir_d;
  logic [3:0]              drain_q, drain_d;
  logic [127:0]            rkbuf_q [NB];
  logic [127:0]            rkbuf_d [NB];
  assign rev = dir_q;
`else
  logic                    dir_unused;
  assign dir_unused = key_dir;
  assign rev        = 1'b0;
`endif

  assign key_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rk_valid  = rk_valid_q;
  assign rk_data   = rk_data_q;
  assign rk_round  = rk_round_q;
  assign rk_last   = rk_valid_q && rk_last_q;
  assign key_err   = key_err_q;

  assign len_bad = (key_len == 2'b11) ||
                   (key_len == 2'b01 && MAX_KEY_BITS < 192) ||
                   (key_len == 2'b10 && MAX_KEY_BITS < 256);

  // Next schedule word w[i] from the key or the sliding window.
  always_comb begin
    old_w = win_q[0];
    for (int k = 0; k < NW; k++)
      if (k + 1 == int'(nk_q)) old_w = win_q[k];
    temp = win_q[0];
    if (j_q == 3'd0)
      temp = sub_word({win_q[0][23:0], win_q[0][31:24]}) ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && j_q == 3'd4)
      temp = sub_word(win_q[0]);
    new_w = (i_q < {2'b00, nk_q}) ? key_q[MAX_KEY_BITS-1 -: 32] : (old_w ^ temp);
  end

  // FSM and datapath next-state.
  always_comb begin
    state_d    = state_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    i_d        = i_q;
    j_d        = j_q;
    rcon_d     = rcon_q;
    key_d      = key_q;
    win_d      = win_q;
    asm_d      = asm_q;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    rk_last_d  = rk_last_q;
    rk_valid_d = rk_valid_q && !rk_ready;
    key_err_d  = 1'b0;
`ifdef AES_KEYEXP_INV_EN
    dir_d      = dir_q;
    drain_d    = drain_q;
    rkbuf_d    = rkbuf_q;
`endif
    round_done = (i_q[1:0] == 2'b11);
    // Reverse mode writes only the buffer, so it never waits on the consumer.
    stall      = round_done && rk_valid_q && !rk_ready && !rev;

    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          if (len_bad) begin
            key_err_d = 1'b1;
          end else begin
            case (key_len)
              2'b00:   begin nk_d = 4'd4; nr_d = 4'd10; end
              2'b01:   begin nk_d = 4'd6; nr_d = 4'd12; end
              default: begin nk_d = 4'd8; nr_d = 4'd14; end
            endcase
            i_d     = 6'd0;
            j_d     = 3'd0;
            rcon_d  = 8'h01;
            key_d   = key_in;
            state_d = S_EXPAND;
`ifdef AES_KEYEXP_INV_EN
            dir_d   = key_dir;
`endif
          end
        end
      end
      S_EXPAND: begin
        if (!stall) begin
          win_d[0] = new_w;
          for (int k = 1; k < NW; k++) win_d[k] = win_q[k-1];
          key_d = key_q << 32;
          i_d   = i_q + 6'd1;
          j_d   = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
          if (i_q >= {2'b00, nk_q} && j_q == 3'd0)
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          case (i_q[1:0])
            2'd0:    asm_d[95:64] = new_w;
            2'd1:    asm_d[63:32] = new_w;
            2'd2:    asm_d[31:0]  = new_w;
            default: ;
          endcase
          if (round_done && !rev) begin
            rk_data_d  = {asm_q, new_w};
            rk_round_d = i_q[5:2];
            rk_valid_d = 1'b1;
            rk_last_d  = (i_q[5:2] == nr_q);
          end
`ifdef AES_KEYEXP_INV_EN
          if (round_done && rev)
            for (int k = 0; k < NB; k++)
              if (k == int'(i_q[5:2])) rkbuf_d[k] = {asm_q, new_w};
`endif
          if (i_q == {nr_q, 2'b11}) begin
            state_d = S_IDLE;
`ifdef AES_KEYEXP_INV_EN
            if (dir_q) state_d = S_DRAIN;
            drain_d = nr_q;
`endif
          end
        end
      end
`ifdef AES_KEYEXP_INV_EN
      S_DRAIN: begin
        if (!rk_valid_q || rk_ready) begin
          for (int k = 0; k < NB; k++)
            if (k == int'(drain_q)) rk_data_d = rkbuf_q[k];
          rk_round_d = drain_q;
          rk_valid_d = 1'b1;
          rk_last_d  = (drain_q == 4'd0);
          if (drain_q == 4'd0) state_d = S_IDLE;
          else                 drain_d = drain_q - 4'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any schedule in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nk_q       <= 4'd0;
      nr_q       <= 4'd0;
      i_q        <= 6'd0;
      j_q        <= 3'd0;
      rcon_q     <= 8'h00;
      key_q      <= '0;
      for (int k = 0; k < NW; k++) win_q[k] <= 32'h0;
      asm_q      <= 96'h0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= 128'h0;
      rk_round_q <= 4'd0;
      rk_last_q  <= 1'b0;
      key_err_q  <= 1'b0;
`ifdef AES_KEYEXP_INV_EN
      dir_q      <= 1'b0;
      drain_q    <= 4'd0;
      for (int k = 0; k < NB; k++) rkbuf_q[k] <= 128'h0;
`endif
    end else begin
      state_q    <= state_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rcon_q     <= rcon_d;
      key_q      <= key_d;
      win_q      <= win_d;
      asm_q      <= asm_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rk_last_q  <= rk_last_d;
      key_err_q  <= key_err_d;
`ifdef AES_KEYEXP_INV_EN
      dir_q      <= dir_d;
      drain_q    <= drain_d;
      rkbuf_q    <= rkbuf_d;
`endif
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Testbench for aes_key_schedule: directed FIPS-197 vectors, random keys with
// random back-pressure, key_len errors, mid-run reset and (when built with
// AES_KEYEXP_INV_EN) reverse delivery. Reference schedule uses an S-box derived
// from GF(2^8) inversion plus the affine map.
`timescale 1ns/1ps
module tb_aes_key_schedule;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid, key_ready, key_dir;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         rk_valid, rk_ready, rk_last, busy, key_err;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;

  logic         s_key_valid, s_key_ready, s_rk_valid, s_rk_last, s_busy, s_key_err;
  logic [127:0] s_key_in, s_rk_data;
  logic [1:0]   s_key_len;
  logic [3:0]   s_rk_round;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got [15];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .key_len(key_len), .key_dir(key_dir),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_round(rk_round), .rk_last(rk_last), .busy(busy), .key_err(key_err)
  );

  aes_key_schedule #(.MAX_KEY_BITS(128)) dut_s (
    .clk(clk), .rst_n(rst_n), .key_valid(s_key_valid), .key_ready(s_key_ready),
    .key_in(s_key_in), .key_len(s_key_len), .key_dir(1'b0),
    .rk_valid(s_rk_valid), .rk_ready(1'b1), .rk_data(s_rk_data),
    .rk_round(s_rk_round), .rk_last(s_rk_last), .busy(s_busy), .key_err(s_key_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic build_ref(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a negedge; returns the cycle count seen at the negedge after the accepting edge.
  task automatic offer(input logic [255:0] key, input logic [1:0] len, input logic dir, output int c0);
    int n;
    n = 0;
    key_in = key; key_len = len; key_dir = dir; key_valid = 1'b1;
    while (!key_ready && n < 200) begin @(negedge clk); n++; end
    if (!key_ready) check("accept_timeout", 128'(key_ready), 128'd1);
    @(negedge clk);
    c0 = cyc;
    key_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, 128'(key_ready), 128'd1);
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
    check({tag, "_rk_data"}, rk_data, 128'd0);
    check({tag, "_rk_round"}, 128'(rk_round), 128'd0);
    check({tag, "_rk_last"}, 128'(rk_last), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_key_err"}, 128'(key_err), 128'd0);
  endtask

  task automatic run_key(input logic [255:0] key, input logic [1:0] len, input logic dir,
                         input bit rnd, input bit timed);
    int nk, nr, c0, idx, budget, r;
    logic hold;
    logic [127:0] held;
    nk = 4 + 2*int'(len);
    nr = nk + 6;
    build_ref(key, nk);
    offer(key, len, dir, c0);
    idx = 0; budget = 0; hold = 1'b0; held = 128'h0;
    while (idx <= nr && budget < 3000) begin
      if (hold) begin
        check("hold_valid", 128'(rk_valid), 128'd1);
        check("hold_data", rk_data, held);
      end
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_valid && rk_ready) begin
        r = dir ? nr - idx : idx;
        check("rk_round", 128'(rk_round), 128'(r));
        check("rk_data", rk_data, exp_rk[r]);
        check("rk_last", 128'(rk_last), 128'(r == (dir ? 0 : nr)));
        got[r] = rk_data;
        if (timed)
          check("rk_time", 128'(cyc - c0), 128'(dir ? 4*nr + 5 + idx : 4*r + 4));
        if (idx == nr) begin
          check("ready_after_last", 128'(key_ready), 128'd1);
          check("busy_after_last", 128'(busy), 128'd0);
        end
        idx++;
      end
      hold = rk_valid && !rk_ready;
      held = rk_data;
      @(negedge clk);
      budget++;
    end
    if (idx <= nr) check("collect_timeout", 128'(idx), 128'(nr + 1));
    rk_ready = 1'b0;
  endtask

  initial begin
    int c0;
    logic [255:0] rk;
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; key_len = 2'b00; key_dir = 1'b0;
    rk_ready = 1'b0;
    s_key_valid = 1'b0; s_key_in = '0; s_key_len = 2'b00;
    build_sbox();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 vectors, no back-pressure, exact timing
    run_key(K128, 2'b00, 1'b0, 1'b0, 1'b1);
    check("aes128_r0", got[0], K128[255:128]);
    check("aes128_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_key(K192, 2'b01, 1'b0, 1'b0, 1'b1);
    check("aes192_w51", 128'(got[12][31:0]), 128'h01002202);
    run_key(K256, 2'b10, 1'b0, 1'b0, 1'b1);
    check("aes256_r14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Random back-pressure on the AES-128 vector, then random keys of every length
    run_key(K128, 2'b00, 1'b0, 1'b1, 1'b0);
    check("bp_aes128_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 8; k++) rk[255 - 32*k -: 32] = $urandom;
      run_key(rk, 2'(t % 3), 1'b0, 1'b1, 1'b0);
    end

    // Reserved key_len on the 256-bit engine
    key_in = K128; key_len = 2'b11; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("err11_pulse", 128'(key_err), 128'd1);
    check("err11_ready", 128'(key_ready), 128'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("err11_quiet", 128'({key_err, rk_valid, busy}), 128'd0);
    end

    // AES-256 length on a 128-bit-only engine
    s_key_in = K128[255:128]; s_key_len = 2'b10; s_key_valid = 1'b1;
    @(negedge clk);
    s_key_valid = 1'b0;
    check("err_narrow_pulse", 128'(s_key_err), 128'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("err_narrow_quiet", 128'({s_key_err, s_rk_valid, s_busy}), 128'd0);
      check("err_narrow_ready", 128'(s_key_ready), 128'd1);
    end

    // Reset asserted at E20 of an AES-256 schedule
    offer(K256, 2'b10, 1'b0, c0);
    rk_ready = 1'b1;
    while (cyc < c0 + 19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 128'(rk_valid), 128'd0);
    end
    rk_ready = 1'b0;
    run_key(K128, 2'b00, 1'b0, 1'b0, 1'b1);
    check("post_rst_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEYEXP_INV_EN
    run_key(K128, 2'b00, 1'b1, 1'b0, 1'b1);
    check("rev_first", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("rev_last", got[0], K128[255:128]);
    run_key(K256, 2'b10, 1'b1, 1'b1, 1'b0);
    run_key(K192, 2'b01, 1'b0, 1'b1, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
